// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan-code, state and ASCII constants for the PS/2 key path
package ps2_pkg;

  // Scan-code set 2 bytes with protocol or modifier meaning
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  // Control characters produced by fixed keys
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] SP = 8'h20;

  // Prefix-tracking states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_ascii_lut.sv
// rtl/ps2_ascii_lut.sv - scan-code set 2 to unshifted/shifted ASCII lookup
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] lower,
  output logic [7:0] upper,
  output logic       is_letter
);

  // Letters only fill in lower; their upper case is derived below
  always_comb begin
    lower     = 8'h00;
    upper     = 8'h00;
    is_letter = 1'b0;
    case (code)
      8'h1C: lower = "a";
      8'h32: lower = "b";
      8'h21: lower = "c";
      8'h23: lower = "d";
      8'h24: lower = "e";
      8'h2B: lower = "f";
      8'h34: lower = "g";
      8'h33: lower = "h";
      8'h43: lower = "i";
      8'h3B: lower = "j";
      8'h42: lower = "k";
      8'h4B: lower = "l";
      8'h3A: lower = "m";
      8'h31: lower = "n";
      8'h44: lower = "o";
      8'h4D: lower = "p";
      8'h15: lower = "q";
      8'h2D: lower = "r";
      8'h1B: lower = "s";
      8'h2C: lower = "t";
      8'h3C: lower = "u";
      8'h2A: lower = "v";
      8'h1D: lower = "w";
      8'h22: lower = "x";
      8'h35: lower = "y";
      8'h1A: lower = "z";
      8'h45: begin lower = "0"; upper = ")"; end
      8'h16: begin lower = "1"; upper = "!"; end
      8'h1E: begin lower = "2"; upper = "@"; end
      8'h26: begin lower = "3"; upper = "#"; end
      8'h25: begin lower = "4"; upper = "$"; end
      8'h2E: begin lower = "5"; upper = "%"; end
      8'h36: begin lower = "6"; upper = "^"; end
      8'h3D: begin lower = "7"; upper = "&"; end
      8'h3E: begin lower = "8"; upper = "*"; end
      8'h46: begin lower = "9"; upper = "("; end
      8'h0E: begin lower = 8'h60; upper = 8'h7E; end
      8'h4E: begin lower = "-"; upper = "_"; end
      8'h55: begin lower = "="; upper = "+"; end
      8'h54: begin lower = "["; upper = "{"; end
      8'h5B: begin lower = "]"; upper = "}"; end
      8'h5D: begin lower = 8'h5C; upper = 8'h7C; end
      8'h4C: begin lower = ";"; upper = ":"; end
      8'h52: begin lower = 8'h27; upper = 8'h22; end
      8'h41: begin lower = ","; upper = "<"; end
      8'h49: begin lower = "."; upper = ">"; end
      8'h4A: begin lower = "/"; upper = "?"; end
      SC_SPACE: begin lower = SP; upper = SP; end
      SC_ENTER: begin lower = CR; upper = CR; end
      SC_BKSP:  begin lower = BS; upper = BS; end
      default: ;
    endcase
    if (lower >= "a" && lower <= "z") begin
      is_letter = 1'b1;
      upper     = lower - 8'h20;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - E0/F0 prefix tracker producing key events, modifiers and ASCII
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       vld,
  input  logic [7:0] data,
  output logic       key_vld,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       ascii_vld,
  output logic [7:0] ascii,
  output logic       caps_led,
  output logic       err
);

  ps2_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic       vld_q;
  logic       shift_l_q, shift_r_q, caps_q, caps_held_q;
  logic       key_vld_q, key_ext_q, key_break_q, ascii_vld_q, err_q;
  logic [7:0] key_code_q, ascii_q;

  logic       byte_stb;
  logic       timeout_hit;
  logic       ev_emit, ev_ext, ev_brk, proto_err;
  logic       is_mod, use_upper, ascii_ok;
  logic [7:0] lut_lower, lut_upper, ascii_sel;
  logic       lut_letter;

  assign byte_stb    = vld & ~vld_q;
  assign timeout_hit = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  ps2_ascii_lut u_lut (
    .code      (data),
    .lower     (lut_lower),
    .upper     (lut_upper),
    .is_letter (lut_letter)
  );

  // Shift is taken before this event's modifier update; caps only affects letters
  assign is_mod    = (data == SC_LSHIFT) || (data == SC_RSHIFT) || (data == SC_CAPS);
  assign use_upper = lut_letter ? ((shift_l_q | shift_r_q) ^ caps_q) : (shift_l_q | shift_r_q);
  assign ascii_sel = use_upper ? lut_upper : lut_lower;
  assign ascii_ok  = ev_emit && !ev_ext && !ev_brk && !is_mod && (ascii_sel != 8'h00);

  // Decode the incoming byte against the current prefix state
  always_comb begin
    state_d   = state_q;
    ev_emit   = 1'b0;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    proto_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data == SC_EXT)                         state_d = ST_EXT;
        else if (data == SC_BRK)                    state_d = ST_BRK;
        else if (data == SC_BAT || data == SC_ACK)  state_d = ST_IDLE;
        else                                        ev_emit = 1'b1;
      end
      ST_EXT: begin
        if (data == SC_BRK)       state_d = ST_EXT_BRK;
        else if (data == SC_EXT)  state_d = ST_EXT;
        else begin
          ev_emit = 1'b1;
          ev_ext  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BRK: begin
        state_d = ST_IDLE;
        if (data == SC_EXT || data == SC_BRK) proto_err = 1'b1;
        else begin
          ev_emit = 1'b1;
          ev_brk  = 1'b1;
        end
      end
      ST_EXT_BRK: begin
        state_d = ST_IDLE;
        if (data == SC_EXT || data == SC_BRK) proto_err = 1'b1;
        else begin
          ev_emit = 1'b1;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, timeout counter, modifier state and registered outputs
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      vld_q       <= 1'b1;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      key_vld_q   <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      ascii_vld_q <= 1'b0;
      ascii_q     <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      vld_q       <= vld;
      key_vld_q   <= 1'b0;
      ascii_vld_q <= 1'b0;
      err_q       <= 1'b0;
      if (byte_stb) begin
        cnt_q   <= '0;
        state_q <= state_d;
        err_q   <= proto_err;
        if (ev_emit) begin
          key_vld_q   <= 1'b1;
          key_code_q  <= data;
          key_ext_q   <= ev_ext;
          key_break_q <= ev_brk;
          if (!ev_ext) begin
            if (data == SC_LSHIFT) shift_l_q <= ~ev_brk;
            if (data == SC_RSHIFT) shift_r_q <= ~ev_brk;
            if (data == SC_CAPS) begin
              if (ev_brk) caps_held_q <= 1'b0;
              else begin
                if (!caps_held_q) caps_q <= ~caps_q;
                caps_held_q <= 1'b1;
              end
            end
          end
          if (ascii_ok) begin
            ascii_vld_q <= 1'b1;
            ascii_q     <= ascii_sel;
          end
        end
      end else if (timeout_hit) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
        cnt_q   <= '0;
      end else if (state_q != ST_IDLE) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign key_vld   = key_vld_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign ascii_vld = ascii_vld_q;
  assign ascii     = ascii_q;
  assign caps_led  = caps_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - table-driven scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int TO = 300;

  logic       clk50 = 1'b0;
  logic       reset;
  logic       vld;
  logic [7:0] data;
  logic       key_vld, key_ext, key_break, ascii_vld, caps_led, err;
  logic [7:0] key_code, ascii;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (
    .clk50     (clk50),
    .reset     (reset),
    .vld       (vld),
    .data      (data),
    .key_vld   (key_vld),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .ascii_vld (ascii_vld),
    .ascii     (ascii),
    .caps_led  (caps_led),
    .err       (err)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       av;
    logic [7:0] asc;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic       ext;
    logic       brk;
    logic       av;
    logic [7:0] asc;
    logic       caps;
  } vec_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   err_cnt = 0;

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pop scoreboard on each key event, count err pulses
  always @(negedge clk50) begin
    if (key_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_key_vld", {24'h0, key_code}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("key_code", {24'h0, key_code}, {24'h0, e.code});
        check("key_ext", {31'h0, key_ext}, {31'h0, e.ext});
        check("key_break", {31'h0, key_break}, {31'h0, e.brk});
        check("ascii_vld", {31'h0, ascii_vld}, {31'h0, e.av});
        if (e.av) check("ascii", {24'h0, ascii}, {24'h0, e.asc});
        check("latency", cyc, e.cyc);
      end
    end else if (ascii_vld) begin
      check("ascii_vld_without_key", 32'h1, 32'h0);
    end
    if (err) err_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input logic ev,
                           input logic ext, input logic brk, input logic av, input logic [7:0] asc);
    exp_t e;
    @(negedge clk50);
    data = b;
    vld  = 1'b1;
    if (ev) begin
      e.code = b; e.ext = ext; e.brk = brk; e.av = av; e.asc = asc; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    repeat (hold) @(negedge clk50);
    vld = 1'b0;
    repeat (4) @(negedge clk50);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   e0;

    //      byte   ev   ext  brk  av   ascii  caps
    vt.push_back('{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h61, 1'b0});
    vt.push_back('{8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    vt.push_back('{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0});
    vt.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    vt.push_back('{8'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    vt.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    vt.push_back('{8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    vt.push_back('{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h61, 1'b0});
    vt.push_back('{8'h58, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h58, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h58, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1});
    vt.push_back('{8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h61, 1'b1});
    vt.push_back('{8'h16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1});
    vt.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h31, 1'b1});
    vt.push_back('{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h75, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h4A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1});
    vt.push_back('{8'h29, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 1'b1});
    vt.push_back('{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b1});
    vt.push_back('{8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1});
    vt.push_back('{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'hFA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h58, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    vt.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    vt.push_back('{8'h58, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});

    // Reset with vld already high; release must not create a byte
    reset = 1'b1;
    vld   = 1'b1;
    data  = 8'h1C;
    repeat (5) @(negedge clk50);
    reset = 1'b0;
    repeat (100) @(negedge clk50);
    check("reset_key_code", {24'h0, key_code}, 32'h0);
    check("reset_ascii", {24'h0, ascii}, 32'h0);
    check("reset_caps_led", {31'h0, caps_led}, 32'h0);
    check("reset_no_err", err_cnt, 0);
    check("reset_no_event", exp_q.size(), 0);
    vld = 1'b0;
    repeat (4) @(negedge clk50);

    // First byte with a long vld level
    send_byte(8'h1C, 500, 1'b1, 1'b0, 1'b0, 1'b1, 8'h61);

    for (int i = 0; i < vt.size(); i++) begin
      send_byte(vt[i].b, 20, vt[i].ev, vt[i].ext, vt[i].brk, vt[i].av, vt[i].asc);
      check($sformatf("caps_led_vec%0d", i), {31'h0, caps_led}, {31'h0, vt[i].caps});
    end
    check("table_no_err", err_cnt, 0);

    // Dangling E0 times out exactly once, then a plain byte is not extended
    e0 = err_cnt;
    send_byte(8'hE0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (TO + 40) @(negedge clk50);
    check("timeout_err_once", err_cnt - e0, 1);
    send_byte(8'h1C, 10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h61);

    // F0 E0 is a protocol error with no event
    e0 = err_cnt;
    send_byte(8'hF0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send_byte(8'hE0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("f0_e0_err", err_cnt - e0, 1);
    send_byte(8'h1C, 10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h61);

    // E0 F0 F0 also errors from the extended-break state
    e0 = err_cnt;
    send_byte(8'hE0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send_byte(8'hF0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send_byte(8'hF0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("ext_brk_err", err_cnt - e0, 1);

    // Reset in the middle of a prefix discards it silently
    e0 = err_cnt;
    send_byte(8'hE0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    repeat (4) @(negedge clk50);
    check("midseq_reset_no_err", err_cnt - e0, 0);
    send_byte(8'h1C, 10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h61);

    repeat (10) @(negedge clk50);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Sequencing controller downstream of the PS/2 byte receiver in the typewriter path, in the clk50 domain. It consumes the receiver's resynchronised vld/data byte stream and tracks the E0/F0 prefix protocol. It emits one key event per complete make or break sequence, maintains shift and caps-lock state, and produces ASCII characters for the text/display stage.

Parameters:
TIMEOUT_CYCLES, 100000, clk50 cycles allowed between prefix and final byte (2 ms) before the sequence is abandoned
CNT_W, 17, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
vld  input  1  byte-valid level from the PS/2 receiver, already synchronised to clk50, high for many cycles per byte
data  input  8  scan-code byte; stable while vld is high
key_vld  output  1  one-cycle pulse: key event valid
key_code  output  8  final scan-code byte of the event
key_ext  output  1  event was E0-prefixed
key_break  output  1  event is a release (F0-prefixed)
ascii_vld  output  1  one-cycle pulse: printable or control character available
ascii  output  8  ASCII character
caps_led  output  1  current caps-lock state
err  output  1  one-cycle pulse: protocol error or timeout

Behaviour:
- Reset is synchronous and active-high.
  - All outputs are 0; state is IDLE; shift_l, shift_r, caps, caps_held and the timeout counter are 0.
  - vld_d resets to 1, so a vld that is already high at reset release is not taken as a new byte.
- Byte accept: byte_stb = vld & ~vld_d, with vld_d registered every cycle. data is sampled on the byte_stb cycle.
- FSM states: IDLE, EXT, BRK, EXT_BRK. On byte_stb:
  - IDLE: E0 -> EXT; F0 -> BRK; AA or FA -> ignored (no event, stay IDLE); otherwise emit make, ext=0.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; otherwise emit make, ext=1, then go to IDLE.
  - BRK: E0 or F0 -> err pulse, go to IDLE, no event; otherwise emit break, ext=0, then go to IDLE.
  - EXT_BRK: E0 or F0 -> err pulse, go to IDLE; otherwise emit break, ext=1, then go to IDLE.
- Latency: key_vld, key_code, key_ext and key_break are registered and assert on the cycle after byte_stb.
  - key_vld and ascii_vld are high for exactly one cycle.
  - key_code, key_ext, key_break and ascii hold their values until the next event.
- Timeout:
  - The counter clears on every byte_stb and counts each cycle while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse err, clear the counter.
  - If byte_stb and the timeout coincide, byte_stb wins: the byte is processed in the current state and no err is raised.
- Modifier tracking (non-ext events only):
  - 0x12 sets shift_l on make and clears it on break; 0x59 does the same for shift_r.
  - 0x58 make toggles caps only when caps_held=0, then sets caps_held; 0x58 break clears caps_held. Typematic repeats therefore do not re-toggle.
  - caps_led = caps.
  - Ext events never change modifiers.
- ASCII generation:
  - Only on non-ext make events whose code is not a modifier. The LUT looks up key_code.
  - If the LUT returns non-zero, ascii_vld pulses in the same cycle as key_vld.
  - Letters (a-z): uppercase when (shift_l|shift_r) XOR caps.
  - Other keys: use the shifted glyph when shift_l|shift_r is set; caps has no effect.
  - Fixed codes: 0x29 -> 0x20 (space), 0x5A -> 0x0D (enter), 0x66 -> 0x08 (backspace).
  - Unmapped codes produce key_vld only.
  - Shift state is the value before the current event is applied.
- A reset asserted mid-sequence discards the partial prefix; no event and no err are produced.

Decomposition:
- Shared package ps2_pkg holds:
  - byte constants: SC_EXT=E0, SC_BRK=F0, SC_BAT=AA, SC_ACK=FA, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58, SC_ENTER=5A, SC_BKSP=66, SC_SPACE=29;
  - the FSM state encoding;
  - ASCII constants CR=0D, BS=08, SP=20.
- One combinational sub-module, ps2_ascii_lut, maps scan-code set 2 to three outputs: lower[7:0], upper[7:0], is_letter.
- All sequential logic stays in ps2_key_decoder.

Test Plan:
- Reset with vld held high, then release; hold vld high 100 cycles -> no key_vld, no err; all outputs 0.
- Byte 0x1C (vld high 500 cycles) -> key_vld once at byte_stb+1; key_code=1C, ext=0, break=0; ascii_vld with ascii=0x61 'a'.
- Sequence 12 (make), 1C, F0 1C, F0 12 -> events make 12 (no ascii), make 1C with ascii 0x41 'A', break 1C, break 12; shift cleared afterwards.
- 58 make twice (repeat), F0 58, then 1C, then 12 1C -> caps_led=1 after the first make only; ascii 0x41 for plain 1C, then 0x61 for shift+1C.
- E0 F0 75 -> a single event: key_code=75, ext=1, break=1; no ascii_vld.
- E0 with no follow-up for TIMEOUT_CYCLES -> err pulse exactly once, state IDLE. A following 1C yields ext=0. F0 E0 -> err pulse, no event.
